fifo_uart_tx: RTL and testbench

Serial transmitter that drains the 12-bit word FIFO and shifts each word out on a single asynchronous-serial line. Sits directly downstream of the FIFO. It watches the FIFO's not-empty flag, pops one word per frame through the FIFO's read strobe, and emits start, data (LSB first), optional even-parity and stop bits at a fixed bit period. Back-to-back frames run with no idle gap while the FIFO holds data.

---
 rtl/fifo_uart_tx_pkg.sv | 24 ++
 rtl/baud_tick_gen.sv | 40 ++++
 rtl/fifo_uart_tx.sv | 127 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg
//   Shared constants for the FIFO-draining serial transmitter: FSM state
//   encodings and the parity-mode selector values.
package fifo_uart_tx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } state_e;

   // Values for the PARITY_EN parameter.
   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen
//   Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of
//   each bit period.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   clear      force the counter to 0 on the next edge
//   last_tick  high while the count is CLKS_PER_BIT-1
module baud_tick_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic last_tick
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count_q, count_d;

   assign last_tick = (count_q == LAST_COUNT);

   always_comb begin
      count_d = count_q + CW'(1);
      if (clear || last_tick) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains a first-word-fall-through FIFO and shifts each word out as an
//   asynchronous serial frame: start, data LSB first, optional even parity,
//   stop. Frames run back to back while the FIFO holds data.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   enable      permits starting new frames
//   fifo_ready  FIFO not empty
//   fifo_data   FIFO head word
//   fifo_read   single-cycle pop strobe to the FIFO
//   tx          serial line, idle high
//   busy        frame in progress
//   frame_done  pulse on the final cycle of each stop bit
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned BITS         = 12,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic            fifo_ready,
   input  logic [BITS-1:0] fifo_data,
   output logic            fifo_read,
   output logic            tx,
   output logic            busy,
   output logic            frame_done
);

   localparam int unsigned IW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BITS - 1);

   state_e            state_q, state_d;
   logic [BITS-1:0]   shift_q, shift_d;
   logic              parity_q, parity_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              last_tick;
   logic              baud_clear;

   // Pop only when idle or on the very last cycle of a stop bit; the rst term
   // keeps the strobe quiet while the block is being reset.
   assign fifo_read = ~rst & enable & fifo_ready &
                      ((state_q == IDLE) | ((state_q == STOP) & last_tick));

   assign busy = (state_q != IDLE);

   // Counter restarts on every state change and stays parked at 0 when idle.
   assign baud_clear = (state_d != state_q) || (state_q == IDLE);

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (baud_clear),
      .last_tick(last_tick)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      idx_d      = idx_q;
      tx         = 1'b1;
      frame_done = 1'b0;

      case (state_q)
         IDLE: begin
            if (fifo_read) state_d = START;
         end
         START: begin
            tx = 1'b0;
            if (last_tick) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            tx = shift_q[0];
            if (last_tick) begin
               shift_d = shift_q >> 1;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = (PARITY_EN == PARITY_EVEN) ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         PARITY: begin
            tx = parity_q;
            if (last_tick) state_d = STOP;
         end
         STOP: begin
            if (last_tick) begin
               frame_done = 1'b1;
               state_d    = fifo_read ? START : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // FWFT head word is valid now; capture it on the popping edge.
      if (fifo_read) begin
         shift_d  = fifo_data;
         parity_d = ^fifo_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         parity_q <= 1'b0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         idx_q    <= idx_d;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

   logic        clk = 1'b0;
   logic        rst, enable, fifo_ready, fifo_read, tx, busy, frame_done;
   logic [11:0] fifo_data;
   logic        enable2, ready2, read2, tx2, busy2, done2;
   logic [11:0] data2;

   always #5 clk = ~clk;

   // FWFT FIFO model feeding the parity build.
   logic [11:0] mem [0:15];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          pops = 0;
   int          cyc = 0;
   int          last_pop_cyc = 0;
   int          prev_pop_cyc = 0;
   logic        flush = 1'b0;

   assign fifo_ready = (wr_ptr != rd_ptr);
   assign fifo_data  = mem[rd_ptr % 16];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (flush) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_read) begin
         rd_ptr       <= rd_ptr + 1;
         pops         <= pops + 1;
         last_pop_cyc <= cyc;
         prev_pop_cyc <= last_pop_cyc;
      end
   end

   int vectors = 0;
   int miscompares = 0;

   fifo_uart_tx #(.BITS(12), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .fifo_ready(fifo_ready),
      .fifo_data(fifo_data), .fifo_read(fifo_read), .tx(tx), .busy(busy),
      .frame_done(frame_done)
   );

   fifo_uart_tx #(.BITS(12), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_np (
      .clk(clk), .rst(rst), .enable(enable2), .fifo_ready(ready2),
      .fifo_data(data2), .fifo_read(read2), .tx(tx2), .busy(busy2),
      .frame_done(done2)
   );

   task automatic push(input logic [11:0] w);
      mem[wr_ptr % 16] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic do_flush;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      enable = 1'b1;
      push(12'h3C3);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if ({tx, fifo_read, busy, frame_done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_hold c=%0d tx/rd/busy/done=%b expected 1000", c,
                     {tx, fifo_read, busy, frame_done});
         end
      end
      enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      do_flush();
   endtask

   task automatic test_single;
      logic [0:14] seq;
      int p0;
      seq = 15'b0_001110100101_0_1;
      push(12'hA5C);
      @(negedge clk);
      enable = 1'b1;
      p0 = pops;
      #1;
      vectors++;
      if (fifo_read !== 1'b1) begin
         miscompares++;
         $display("FAIL single_pop fifo_read=%b expected 1", fifo_read);
      end
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         vectors++;
         if ({tx, busy, frame_done, fifo_read} !== {seq[(k-1)/4], 1'b1, (k == 60), 1'b0}) begin
            miscompares++;
            $display("FAIL single_frame k=%0d tx/busy/done/rd=%b expected %b", k,
                     {tx, busy, frame_done, fifo_read}, {seq[(k-1)/4], 1'b1, (k == 60), 1'b0});
         end
      end
      @(negedge clk);
      vectors++;
      if ({tx, busy, pops - p0} !== {1'b1, 1'b0, 32'd1}) begin
         miscompares++;
         $display("FAIL single_after tx=%b busy=%b pops=%0d expected 1 0 1", tx, busy, pops - p0);
      end
      enable = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [0:14] s1, s2;
      logic        exp;
      int p0;
      s1 = 15'b0_100000000000_1_1;
      s2 = 15'b0_111111111111_0_1;
      push(12'h001);
      push(12'hFFF);
      @(negedge clk);
      enable = 1'b1;
      p0 = pops;
      #1;
      vectors++;
      if (fifo_read !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_pop fifo_read=%b expected 1", fifo_read);
      end
      for (int k = 1; k <= 120; k++) begin
         @(negedge clk);
         exp = (k <= 60) ? s1[(k-1)/4] : s2[(k-61)/4];
         vectors++;
         if ({tx, busy, frame_done, fifo_read} !==
             {exp, 1'b1, (k == 60 || k == 120), (k == 60)}) begin
            miscompares++;
            $display("FAIL b2b_frame k=%0d tx/busy/done/rd=%b expected %b", k,
                     {tx, busy, frame_done, fifo_read},
                     {exp, 1'b1, (k == 60 || k == 120), (k == 60)});
         end
      end
      @(negedge clk);
      vectors++;
      if ({tx, busy} !== 2'b10 || pops - p0 != 2 || last_pop_cyc - prev_pop_cyc != 60) begin
         miscompares++;
         $display("FAIL b2b_after tx=%b busy=%b pops=%0d gap=%0d expected 1 0 2 60", tx, busy,
                  pops - p0, last_pop_cyc - prev_pop_cyc);
      end
      enable = 1'b0;
   endtask

   task automatic test_enable_drop;
      logic [0:14] seq;
      int p0;
      seq = 15'b0_110001001000_0_1;
      push(12'h123);
      push(12'h456);
      push(12'h789);
      @(negedge clk);
      enable = 1'b1;
      p0 = pops;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         vectors++;
         if ({tx, busy, frame_done, fifo_read} !== {seq[(k-1)/4], 1'b1, (k == 60), 1'b0}) begin
            miscompares++;
            $display("FAIL endrop_frame k=%0d tx/busy/done/rd=%b expected %b", k,
                     {tx, busy, frame_done, fifo_read}, {seq[(k-1)/4], 1'b1, (k == 60), 1'b0});
         end
         if (k == 20) enable = 1'b0;
      end
      for (int k = 61; k <= 68; k++) begin
         @(negedge clk);
         vectors++;
         if ({tx, busy, fifo_read} !== 3'b100) begin
            miscompares++;
            $display("FAIL endrop_idle k=%0d tx/busy/rd=%b expected 100", k,
                     {tx, busy, fifo_read});
         end
      end
      vectors++;
      if (pops - p0 != 1) begin
         miscompares++;
         $display("FAIL endrop_pops pops=%0d expected 1", pops - p0);
      end
      do_flush();
   endtask

   task automatic test_reset_mid_frame;
      logic [0:14] s1, s2;
      int p0;
      s1 = 15'b0_001110100101_0_1;
      s2 = 15'b0_100000000000_1_1;
      push(12'hA5C);
      push(12'h001);
      @(negedge clk);
      enable = 1'b1;
      p0 = pops;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         vectors++;
         if (tx !== s1[(k-1)/4]) begin
            miscompares++;
            $display("FAIL rstmid_pre k=%0d tx=%b expected %b", k, tx, s1[(k-1)/4]);
         end
      end
      rst = 1'b1;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         vectors++;
         if ({tx, busy, fifo_read, frame_done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL rstmid_hold r=%0d tx/busy/rd/done=%b expected 1000", r,
                     {tx, busy, fifo_read, frame_done});
         end
      end
      vectors++;
      if (pops - p0 != 1) begin
         miscompares++;
         $display("FAIL rstmid_pops pops=%0d expected 1", pops - p0);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (fifo_read !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_repop fifo_read=%b expected 1", fifo_read);
      end
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         vectors++;
         if ({tx, busy, frame_done} !== {s2[(k-1)/4], 1'b1, (k == 60)}) begin
            miscompares++;
            $display("FAIL rstmid_frame k=%0d tx/busy/done=%b expected %b", k,
                     {tx, busy, frame_done}, {s2[(k-1)/4], 1'b1, (k == 60)});
         end
      end
      enable = 1'b0;
      @(negedge clk);
      vectors++;
      if ({tx, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL rstmid_after tx=%b busy=%b expected 1 0", tx, busy);
      end
   endtask

   task automatic test_no_parity;
      logic [0:13] seq;
      seq = 14'b0_001110100101_1;
      @(negedge clk);
      data2   = 12'hA5C;
      ready2  = 1'b1;
      enable2 = 1'b1;
      #1;
      vectors++;
      if (read2 !== 1'b1) begin
         miscompares++;
         $display("FAIL nopar_pop fifo_read=%b expected 1", read2);
      end
      for (int k = 1; k <= 56; k++) begin
         @(negedge clk);
         ready2 = 1'b0;
         vectors++;
         if ({tx2, busy2, done2} !== {seq[(k-1)/4], 1'b1, (k == 56)}) begin
            miscompares++;
            $display("FAIL nopar_frame k=%0d tx/busy/done=%b expected %b", k,
                     {tx2, busy2, done2}, {seq[(k-1)/4], 1'b1, (k == 56)});
         end
      end
      @(negedge clk);
      vectors++;
      if ({tx2, busy2} !== 2'b10) begin
         miscompares++;
         $display("FAIL nopar_after tx=%b busy=%b expected 1 0", tx2, busy2);
      end
      enable2 = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      enable  = 1'b0;
      enable2 = 1'b0;
      ready2  = 1'b0;
      data2   = 12'h000;
      test_reset();
      test_single();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid_frame();
      test_no_parity();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
